moore_seq_gen: RTL and testbench
================================

# moore_seq_gen

Serial sequence generator: the transmit-side counterpart of the Moore non-overlapping sequence detector. On a start request it emits a fixed LEN-bit pattern, MSB first, one bit per clock, repeated a programmable number of times. It drives the `in` pin of the detector in loopback benches and on-chip self-test, producing frames the detector must count exactly once each.

## Interface
- `LEN`, default 4: pattern length in bits, 2..16.
- `PATTERN`, default 4'b1011: pattern bits, transmitted `PATTERN[LEN-1]` first.
- `IDLE_BIT`, default 1'b0: line value whenever no pattern bit is being driven.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `start`  in  1: request; sampled only in IDLE.
- `count`  in  4: number of pattern repetitions, latched on accepted start.
- `out`  out  1: serial bit stream.
- `valid`  out  1: high while `out` carries a pattern bit.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.

## Operation
- Moore FSM; all outputs are registered or decoded from state/registers only, never from `start` or `count` directly.
- States: IDLE, SEND, GAP, DONE.
- IDLE: `out`=IDLE_BIT, `valid`=0, `busy`=0, `done`=0. With `start`=1 and `count`≠0: latch `count` into a repetition counter, load `PATTERN` into the shift register, bit index = LEN-1, go to SEND. With `start`=1 and `count`=0: go to DONE with nothing transmitted.
- SEND: `out`=shift-register MSB, `valid`=1. Shift left each cycle and decrement the bit index.
  - After the last bit (index 0), decrement the repetition counter.
  - Counter now 0: go to DONE.
  - Otherwise reload `PATTERN` and go to GAP (macro defined) or stay in SEND (macro undefined).
- GAP: exactly one cycle, `out`=IDLE_BIT, `valid`=0, then SEND.
- DONE: exactly one cycle, `done`=1, `out`=IDLE_BIT, then IDLE.
- `start` outside IDLE is ignored; `count` changes after acceptance have no effect.
- Reset mid-frame: at the first edge with `rst`=0, go to IDLE with all outputs at their IDLE values, shift register cleared, repetition counter cleared. A partial frame is simply truncated.

## Timing
- Reset values: `out`=IDLE_BIT, `valid`=0, `busy`=0, `done`=0.
- Latency: `start` is sampled at edge E. The first pattern bit appears after E, for the cycle E..E+1.
- Each bit is held exactly one cycle.
- Frame length is `count`×LEN cycles without gap, or `count`×(LEN+1)−1 cycles with gap. `done` follows in the next cycle.
- Back-to-back operation: a `start` held high at the DONE→IDLE edge is not accepted. The minimum start-to-start spacing is frame length + 2 cycles.

## Configuration
- `SEQ_GEN_GAP_EN` defined: one IDLE_BIT guard cycle between consecutive repetitions. This keeps frames separated for non-overlapping detection.
- `SEQ_GEN_GAP_EN` undefined: the GAP state is not compiled in, and repetitions are sent back-to-back.

## Structure
- Package `seq_pkg`:
  - state encoding enum: IDLE=2'd0, SEND=2'd1, GAP=2'd2, DONE=2'd3
  - `SEQ_DEFAULT_PATTERN`=4'b1011
  - `SEQ_DEFAULT_LEN`=4
- Sub-module `seq_shift_reg`: LEN-wide loadable left-shift register with bit-index down-counter and `last` flag. The FSM owns sequencing and the repetition counter.

## Test plan
- `count`=1, default params: `out`=1,0,1,1 on cycles 1–4 after start with `valid`=1, then `done`=1 on cycle 5, then `busy`=0.
- `count`=3, macro undefined → 12 contiguous bits 101110111011. With macro defined → 10110101101011 (14 cycles). `done` follows in the next cycle in both cases.
- `count`=0 → `valid` never asserted; `done` pulses the cycle after start.
- `start` pulsed during SEND → no effect on the stream; exactly one `done` per accepted start.
- `rst`=0 at the third bit of the second repetition → next cycle `out`=0, `valid`=0, `busy`=0. A fresh start then produces a complete, correct frame.
- Loopback into the detector (macro defined), `count`=5 → detector `detected` asserts exactly 5 times.

Source files
------------

// File: rtl/moore_seq_gen_pkg.sv
// rtl/moore_seq_gen_pkg.sv - shared state encoding and defaults for the serial sequence generator
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam logic [3:0] SEQ_DEFAULT_PATTERN = 4'b1011;
  localparam int         SEQ_DEFAULT_LEN     = 4;
  localparam int         SEQ_COUNT_W         = 4;

endpackage

// File: rtl/moore_seq_gen_if.sv
// rtl/moore_seq_gen_if.sv - request/stream bundle between a requester and the sequence generator
interface moore_seq_gen_if;
  import seq_pkg::*;

  logic                   start;
  logic [SEQ_COUNT_W-1:0] count;
  logic                   out;
  logic                   valid;
  logic                   busy;
  logic                   done;

  modport master (
    output start,
    output count,
    input  out,
    input  valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  count,
    output out,
    output valid,
    output busy,
    output done
  );

endinterface

// File: rtl/moore_seq_gen_shift_reg.sv
// rtl/moore_seq_gen_shift_reg.sv - loadable left-shift register with bit-index down-counter
module seq_shift_reg
  import seq_pkg::*;
#(
  parameter int             LEN     = SEQ_DEFAULT_LEN,
  parameter logic [LEN-1:0] PATTERN = LEN'(SEQ_DEFAULT_PATTERN)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  output logic msb,
  output logic last
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [LEN-1:0] sr;
  logic [IW-1:0]  idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= PATTERN;
      idx <= IW'(LEN - 1);
    end else if (shift) begin
      sr  <= {sr[LEN-2:0], 1'b0};
      idx <= idx - IW'(1);
    end
  end

  assign msb  = sr[LEN-1];
  assign last = (idx == '0);

endmodule

// File: rtl/moore_seq_gen.sv
// rtl/moore_seq_gen.sv - Moore FSM emitting PATTERN count times, MSB first
// SEQ_GEN_GAP_EN: insert one IDLE_BIT guard cycle between repetitions.
module moore_seq_gen
  import seq_pkg::*;
#(
  parameter int             LEN      = SEQ_DEFAULT_LEN,
  parameter logic [LEN-1:0] PATTERN  = LEN'(SEQ_DEFAULT_PATTERN),
  parameter logic           IDLE_BIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  moore_seq_gen_if.slave  bus
);

  seq_state_t             state;
  seq_state_t             state_next;
  logic [SEQ_COUNT_W-1:0] rep;
  logic                   rep_load;
  logic                   rep_dec;
  logic                   sr_load;
  logic                   sr_shift;
  logic                   sr_msb;
  logic                   sr_last;

  seq_shift_reg #(
    .LEN     (LEN),
    .PATTERN (PATTERN)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .msb   (sr_msb),
    .last  (sr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rep   <= '0;
    end else begin
      state <= state_next;
      if (rep_load) begin
        rep <= bus.count;
      end else if (rep_dec) begin
        rep <= rep - SEQ_COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    rep_load   = 1'b0;
    rep_dec    = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            rep_load   = 1'b1;
            sr_load    = 1'b1;
            state_next = SEND;
          end else begin
            state_next = DONE;
          end
        end
      end
      SEND: begin
        if (sr_last) begin
          rep_dec = 1'b1;
          // rep still holds the pre-decrement value here, so 1 means final repetition
          if (rep == SEQ_COUNT_W'(1)) begin
            state_next = DONE;
          end else begin
            sr_load = 1'b1;
`ifdef SEQ_GEN_GAP_EN
            state_next = GAP;
`else
            state_next = SEND;
`endif
          end
        end else begin
          sr_shift = 1'b1;
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        state_next = SEND;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.out   = (state == SEND) ? sr_msb : IDLE_BIT;
  assign bus.valid = (state == SEND);
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_moore_seq_gen.sv
// tb/tb_moore_seq_gen.sv - directed self-checking bench with a per-cycle stream model
module tb_moore_seq_gen;
  import seq_pkg::*;

  localparam int         LEN = 4;
  localparam logic [3:0] PAT = 4'b1011;
`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam logic [3:0] IDLE_V = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  moore_seq_gen_if bus ();

  moore_seq_gen #(
    .LEN      (LEN),
    .PATTERN  (PAT),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Each entry is the expected {out, valid, busy, done} for one cycle.
  always @(negedge clk) begin
    logic [3:0] e;
    if (cmp_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
      check("stream", {28'd0, bus.out, bus.valid, bus.busy, bus.done}, {28'd0, e});
    end
  end

  task automatic model_frame(input int cnt);
    logic [3:0] p;
    p = PAT;
    exp_q.push_back(IDLE_V);
    for (int r = 0; r < cnt; r++) begin
      for (int b = 0; b < LEN; b++) exp_q.push_back({p[LEN-1-b], 1'b1, 1'b1, 1'b0});
      if (GAP_EN && r < cnt - 1) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
  endtask

  task automatic start_frame(input int cnt);
    bus.start = 1'b1;
    bus.count = 4'(cnt);
    model_frame(cnt);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] bits);
    bits = '0;
    repeat (n) begin
      @(negedge clk);
      bits = {bits[30:0], bus.out};
    end
  endtask

  initial begin
    logic [31:0] bits;
    logic [31:0] lit;
    logic [3:0]  win;
    int n, k, det, since, dones;

    bus.start = 1'b0;
    bus.count = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", bus.out, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;

    // single repetition
    start_frame(1);
    capture(4, bits);
    check("cnt1_bits", bits, 32'b1011);
    @(negedge clk);
    check("cnt1_done", bus.done, 1);
    @(negedge clk);
    check("cnt1_busy_after", bus.busy, 0);
    @(posedge clk);
    #1;

    // three repetitions
    start_frame(3);
    n   = GAP_EN ? 14 : 12;
    lit = GAP_EN ? 32'b10110101101011 : 32'b101110111011;
    capture(n, bits);
    check("cnt3_bits", bits, lit);
    @(negedge clk);
    check("cnt3_done", bus.done, 1);
    @(posedge clk);
    #1;

    // zero count: done only
    start_frame(0);
    @(negedge clk);
    check("cnt0_done", bus.done, 1);
    check("cnt0_valid", bus.valid, 0);
    @(posedge clk);
    #1;

    // start pulse and count change while sending
    start_frame(2);
    bus.count = 4'd4;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("one_done_per_start", dones, 1);
    @(posedge clk);
    #1;

    // reset at the third bit of the second repetition
    start_frame(2);
    k = LEN + (GAP_EN ? 1 : 0) + 3;
    repeat (k - 1) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("abort_out", bus.out, 0);
    check("abort_valid", bus.valid, 0);
    check("abort_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    start_frame(1);
    capture(4, bits);
    check("after_abort_bits", bits, 32'b1011);
    @(negedge clk);
    check("after_abort_done", bus.done, 1);
    @(posedge clk);
    #1;

    // loopback: non-overlapping 1011 detector over the emitted line
    start_frame(5);
    n = 5 * LEN + (GAP_EN ? 4 : 0);
    win = '0;
    since = 0;
    det = 0;
    repeat (n) begin
      @(negedge clk);
      win = {win[2:0], bus.out};
      since++;
      if (since >= 4 && win == 4'b1011) begin
        det++;
        since = 0;
      end
    end
    check("loopback_detections", det, 5);
    @(negedge clk);
    check("loopback_done", bus.done, 1);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
